// File: rtl/ram_dual_port.sv
// ---------------------------------------------------------------------------
// ram_dual_port
//
// Synchronous simple-dual-port RAM with one write port and one read port on a
// single clock. Reads are registered: data_out and rd_valid change after the
// rising edge that samples rd_enb and hold until the next accepted read
// (data_out) or the next edge (rd_valid). Addresses at or beyond DEPTH are
// tolerated: out-of-range writes are dropped, out-of-range reads return zero.
//
// Optional feature (compile-time macro RAM_BYPASS_EN):
//   defined   -> write-first: a same-edge, same-address read returns data_in
//   undefined -> read-first : a same-edge, same-address read returns old data
//
// Parameters:
//   DATA_WIDTH  width of a data word
//   DEPTH       number of words (need not be a power of two)
//   ADDR_WIDTH  derived address width, not meant to be overridden
//
// Ports:
//   clk       in   single clock, rising-edge active
//   rst       in   asynchronous active-high reset (clears memory and outputs)
//   wr_enb    in   write request
//   wr_addr   in   write address
//   data_in   in   write data
//   rd_enb    in   read request
//   rd_addr   in   read address
//   data_out  out  registered read data
//   rd_valid  out  one-cycle strobe marking data_out as a fresh read result
// ---------------------------------------------------------------------------
module ram_dual_port #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid
);

  // One extra bit so DEPTH itself is representable for the range compare.
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_rd_valid;

  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_wr_ok = wr_enb && ({1'b0, wr_addr} < LP_DEPTH);
  assign w_rd_ok = {1'b0, rd_addr} < LP_DEPTH;

  // Select the word a read would return this edge (zero when out of range).
  always_comb begin
    w_rd_data = '0;
    if (w_rd_ok) begin
`ifdef RAM_BYPASS_EN
      // Write-first: forward the incoming word on a same-address collision.
      if (w_wr_ok && (wr_addr == rd_addr)) begin
        w_rd_data = data_in;
      end else begin
        w_rd_data = r_mem[rd_addr];
      end
`else
      w_rd_data = r_mem[rd_addr];
`endif
    end else begin
      w_rd_data = '0;
    end
  end

  // Storage array: cleared on reset, written on in-range write requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= data_in;
    end
  end

  // Read port: data_out updates only on accepted reads, rd_valid follows rd_enb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_enb;
      if (rd_enb) begin
        r_data_out <= w_rd_data;
      end
    end
  end

  assign data_out = r_data_out;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_ram_dual_port.sv
module tb_ram_dual_port;

  logic       clk;
  logic       rst;
  logic       wr_enb;
  logic [3:0] wr_addr;
  logic [7:0] data_in;
  logic       rd_enb;
  logic [3:0] rd_addr;
  logic [7:0] data_out;
  logic       rd_valid;
  logic [7:0] data_out_s;
  logic       rd_valid_s;

  int n_cmp;
  int n_bad;

  ram_dual_port #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .data_in(data_in),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .data_out(data_out), .rd_valid(rd_valid)
  );

  // Second instance with a non-power-of-two depth for out-of-range checks.
  ram_dual_port #(.DATA_WIDTH(8), .DEPTH(12)) dut_s (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .data_in(data_in),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .data_out(data_out_s), .rd_valid(rd_valid_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_enb = 1'b1; wr_addr = a; data_in = d; rd_enb = 1'b0;
    cyc();
    wr_enb = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_enb = 1'b1; rd_addr = a; wr_enb = 1'b0;
    cyc();
    rd_enb = 1'b0;
  endtask

  logic [7:0] exp_col;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; wr_enb = 1'b0; wr_addr = 4'd0; data_in = 8'd0;
    rd_enb = 1'b0; rd_addr = 4'd0;
    cyc(); cyc();
    chk("reset_data", data_out, 8'h00);
    chk("reset_valid", {7'd0, rd_valid}, 8'h00);
    rst = 1'b0;

    // Reset check: load a nonzero word, read it, then reset mid-cycle.
    wr(4'd3, 8'hA5);
    rd_enb = 1'b1; rd_addr = 4'd3;
    cyc();
    chk("pre_rst_data", data_out, 8'hA5);
    chk("pre_rst_valid", {7'd0, rd_valid}, 8'h01);
    #3;
    rst = 1'b1;
    wr_enb = 1'b1; wr_addr = 4'd5; data_in = 8'h77;
    #1;
    chk("async_rst_data", data_out, 8'h00);
    chk("async_rst_valid", {7'd0, rd_valid}, 8'h00);
    cyc(); cyc();
    chk("rst_hold_data", data_out, 8'h00);
    chk("rst_hold_valid", {7'd0, rd_valid}, 8'h00);
    rst = 1'b0; wr_enb = 1'b0;
    rd(4'd3);
    chk("post_rst_rd3", data_out, 8'h00);
    chk("post_rst_valid", {7'd0, rd_valid}, 8'h01);
    rd(4'd5);
    chk("rst_ignores_wr", data_out, 8'h00);

    // Write 0x11..0x1F to 1..15, read back descending with idle gaps.
    for (int a = 1; a < 16; a++) wr(4'(a), 8'(8'h10 + a));
    for (int a = 15; a >= 1; a--) begin
      rd(4'(a));
      chk("wr_rd_data", data_out, 8'(8'h10 + a));
      chk("wr_rd_valid", {7'd0, rd_valid}, 8'h01);
      cyc();
      chk("wr_rd_strobe", {7'd0, rd_valid}, 8'h00);
      chk("wr_rd_hold", data_out, 8'(8'h10 + a));
    end

    // Back-to-back reads over a pattern of addr ^ 0x3C.
    for (int a = 0; a < 16; a++) wr(4'(a), 8'(a) ^ 8'h3C);
    rd_enb = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      cyc();
      chk("b2b_data", data_out, 8'(a) ^ 8'h3C);
      chk("b2b_valid", {7'd0, rd_valid}, 8'h01);
    end
    rd_enb = 1'b0;
    cyc();
    chk("b2b_end_valid", {7'd0, rd_valid}, 8'h00);

    // Same-address collision: result depends on the bypass build option.
    wr(4'd7, 8'h22);
    wr_enb = 1'b1; wr_addr = 4'd7; data_in = 8'h99;
    rd_enb = 1'b1; rd_addr = 4'd7;
    cyc();
`ifdef RAM_BYPASS_EN
    exp_col = 8'h99;
`else
    exp_col = 8'h22;
`endif
    chk("collide_data", data_out, exp_col);
    chk("collide_valid", {7'd0, rd_valid}, 8'h01);
    rd(4'd7);
    chk("collide_after", data_out, 8'h99);

    // Different addresses in the same edge: write 4, read 5 (holds 5^0x3C).
    wr_enb = 1'b1; wr_addr = 4'd4; data_in = 8'h44;
    rd_enb = 1'b1; rd_addr = 4'd5;
    cyc();
    chk("diff_rd5", data_out, 8'h39);
    rd(4'd4);
    chk("diff_wr4", data_out, 8'h44);

    // Idle hold: data_out keeps 0x5A while other addresses are written.
    wr(4'd9, 8'h5A);
    rd(4'd9);
    chk("idle_first", data_out, 8'h5A);
    for (int k = 0; k < 4; k++) begin
      wr_enb = 1'b1; wr_addr = 4'(10 + k); data_in = 8'(8'hC0 + k);
      rd_enb = 1'b0; rd_addr = 4'd9;
      cyc();
      chk("idle_valid", {7'd0, rd_valid}, 8'h00);
      chk("idle_data", data_out, 8'h5A);
    end
    wr_enb = 1'b0;
    rd(4'd12);
    chk("idle_wr_landed", data_out, 8'hC2);

    // Out-of-range on the 12-deep instance.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wr(4'd11, 8'h6B);
    wr(4'd13, 8'hFF);
    rd(4'd11);
    chk("oor_rd11_a", data_out_s, 8'h6B);
    rd(4'd13);
    chk("oor_rd13_data", data_out_s, 8'h00);
    chk("oor_rd13_valid", {7'd0, rd_valid_s}, 8'h01);
    chk("inrange_rd13", data_out, 8'hFF);
    rd(4'd11);
    chk("oor_rd11_b", data_out_s, 8'h6B);
    for (int a = 0; a < 11; a++) begin
      rd(4'(a));
      chk("oor_no_corrupt", data_out_s, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
